// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Two-port round-robin arbiter/sequencer for a single-ported
//               block RAM with rd/wr strobes and an mwait busy input.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mem_arbiter #(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ack,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ack,
  output logic [DW-1:0] b_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_d,
  output logic          mem_rd,
  output logic          mem_wr,
  input  logic [DW-1:0] mem_q,
  input  logic          mem_mwait
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic c_port_a = 1'b0;
  localparam logic c_port_b = 1'b1;

  state_t        r_state;
  logic          r_last_grant;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_mem_rd;
  logic          r_mem_wr;
  logic          r_a_ack;
  logic          r_b_ack;
  logic [DW-1:0] r_a_rdata;
  logic [DW-1:0] r_b_rdata;

  logic          w_any_req;
  logic          w_pick_b;
  logic          w_we;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;

  // B wins only when A is idle or A was served last.
  always_comb begin
    w_any_req = a_req | b_req;
    w_pick_b  = b_req & (~a_req | (r_last_grant == c_port_a));
    w_we      = w_pick_b ? b_we    : a_we;
    w_addr    = w_pick_b ? b_addr  : a_addr;
    w_wdata   = w_pick_b ? b_wdata : a_wdata;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_last_grant <= c_port_b;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_mem_rd     <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_a_ack      <= 1'b0;
      r_b_ack      <= 1'b0;
      r_a_rdata    <= '0;
      r_b_rdata    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req && !mem_mwait) begin
            r_last_grant <= w_pick_b;
            r_we         <= w_we;
            r_addr       <= w_addr;
            r_wdata      <= w_wdata;
            r_mem_rd     <= ~w_we;
            r_mem_wr     <= w_we;
            r_state      <= ISSUE;
          end
        end
        ISSUE: begin
          r_mem_rd <= 1'b0;
          r_mem_wr <= 1'b0;
          r_state  <= BUSY;
        end
        BUSY: begin
          if (!mem_mwait) begin
            if (!r_we) begin
              if (r_last_grant == c_port_b) r_b_rdata <= mem_q;
              else                          r_a_rdata <= mem_q;
            end
            r_a_ack <= (r_last_grant == c_port_a);
            r_b_ack <= (r_last_grant == c_port_b);
            r_state <= DONE;
          end
        end
        DONE: begin
          r_a_ack <= 1'b0;
          r_b_ack <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Address and data stay on the latched registers so the memory can sample late.
  assign mem_addr = r_addr;
  assign mem_d    = r_wdata;
  assign mem_rd   = r_mem_rd;
  assign mem_wr   = r_mem_wr;
  assign a_ack    = r_a_ack;
  assign b_ack    = r_b_ack;
  assign a_rdata  = r_a_rdata;
  assign b_rdata  = r_b_rdata;

`ifndef SYNTHESIS
  a_strobe_excl : assert property (@(posedge clock) disable iff (!reset_n)
    !(r_mem_rd && r_mem_wr));
  a_strobe_pulse : assert property (@(posedge clock) disable iff (!reset_n)
    (r_mem_rd || r_mem_wr) |=> !(r_mem_rd || r_mem_wr));
  a_ack_excl : assert property (@(posedge clock) disable iff (!reset_n)
    !(r_a_ack && r_b_ack));
`endif

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port round-robin arbiter and sequencer for the single-ported 1024x16 block RAM. It sits between the processor core (port A) and the loader/debug port (port B) and converts their level-held request/acknowledge handshakes into the memory's `rd`/`wr`/`mwait` protocol. It holds the memory address and write data stable for the whole transaction, captures read data, and returns a one-cycle acknowledge to the granted requester.

## Interface
- `AW`, 10, address width
- `DW`, 16, data width

- `clock`  in  1  single system clock, rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `a_req`  in  1  port A request, held high until `a_ack`
- `a_we`  in  1  port A write (1) / read (0)
- `a_addr`  in  AW  port A address
- `a_wdata`  in  DW  port A write data
- `a_ack`  out  1  port A one-cycle completion pulse
- `a_rdata`  out  DW  port A read data, valid when `a_ack`=1, held until that port's next read completes
- `b_req`, `b_we`, `b_addr`, `b_wdata`, `b_ack`, `b_rdata`: same as port A, for port B
- `mem_addr`  out  AW  to memory `addr`
- `mem_d`  out  DW  to memory `d`
- `mem_rd`  out  1  to memory `rd`
- `mem_wr`  out  1  to memory `wr`
- `mem_q`  in  DW  from memory `q`
- `mem_mwait`  in  1  from memory `mwait` (busy)

## Operation
- FSM states: IDLE, ISSUE, BUSY, DONE.
- IDLE:
  - Grant only when at least one `req` is high and `mem_mwait`=0.
  - Latch the winner's `we`, `addr` and `wdata` into internal registers, record the winner in `last_grant`, and go to ISSUE.
  - With no request, or with `mem_mwait`=1, stay in IDLE.
- Arbitration:
  - One requester: that port wins.
  - Both requesting: the port not in `last_grant` wins.
  - `last_grant` resets to B, so A wins the first contention.
- ISSUE, one cycle:
  - `mem_rd`=!we or `mem_wr`=we for exactly this cycle.
  - `mem_addr` and `mem_d` are driven from the latched registers. Go to BUSY.
- BUSY:
  - Stay while `mem_mwait`=1.
  - When `mem_mwait`=0: for a read, register `mem_q` into the granted port's `rdata`; assert the granted port's `ack`; go to DONE.
- DONE, one cycle: the `ack` is high for this cycle only. No requests are sampled. Go to IDLE.
- `mem_addr` and `mem_d` come directly from the latched registers. They stay constant from ISSUE through DONE, because the memory samples the address one cycle after `rd`/`wr`.
- Requester rule: drop `req` on the clock edge that ends the `ack` cycle, or keep it high to make a new request. A request seen in the IDLE cycle after DONE is a new transaction.
- The non-granted port's `ack` stays 0 and its `rdata` is unchanged.
- A write does not modify the writing port's `rdata`.

## Timing
- Reset (`reset_n`=0 at a rising edge):
  - state goes to IDLE; `last_grant` goes to B.
  - `mem_rd`, `mem_wr`, `a_ack` and `b_ack` are 0.
  - `mem_addr`, `mem_d`, `a_rdata` and `b_rdata` are 0.
- Read, single requester, `req` seen in IDLE at cycle 0:
  - cycle 1: ISSUE, `mem_rd`=1.
  - cycles 2-3: BUSY, `mem_mwait`=1.
  - cycle 4: `mem_mwait`=0, `mem_q` captured.
  - cycle 5: DONE, `ack`=1, `rdata` valid.
  - cycle 6: IDLE.
  - Request-to-ack latency is 5 cycles.
- Write: same schedule with `mem_wr`=1 in cycle 1 and `ack` in cycle 5.
- Back-to-back throughput is one transaction per 6 cycles.
- Reset mid-transaction: the FSM aborts to IDLE and no `ack` is issued. If the memory is still busy, `mem_mwait`=1 holds the arbiter in IDLE until the memory is free. A write already issued may complete.
- `mem_rd` and `mem_wr` are never high together. Each is never high for more than one consecutive cycle.
- A requester lowering `req` before its `ack` is illegal; the transaction still completes.

## Test plan
- Port A reads address 0x005, which was preloaded with 0x1234 -> `mem_rd` pulses in cycle 1, `a_ack` pulses in cycle 5 with `a_rdata`=0x1234, `b_ack` stays 0.
- Port B writes 0xBEEF to 0x3FF, then port B reads 0x3FF -> `b_ack` for the write in cycle 5 with `b_rdata` unchanged; the read returns 0xBEEF after 5 more cycles; `mem_addr`=0x3FF held through ISSUE..DONE.
- A and B both read continuously (A at 0x001=0x1111, B at 0x002=0x2222) -> grants alternate A, B, A, B starting with A; each `ack` is 6 cycles apart; data is never crossed between ports.
- `mem_mwait` is forced high for 4 extra cycles during BUSY -> `ack` is delayed by 4 cycles, and the rd/wr pulse count stays at 1.
- `reset_n` is pulled low during BUSY of a port A read -> no `a_ack`, all outputs return to reset values, and the next `a_req` is granted only after `mem_mwait`=0.
- `a_req` is held high through its `ack` -> a second transaction starts in the IDLE cycle after DONE. A simultaneous new `b_req` wins that arbitration instead (round-robin).
